// File: rtl/uart_mem_sequencer.sv
// uart_mem_sequencer: the UART-side job sequencer for the instruction and image RAMs.
// A job loads the program bytes and then the image bytes. It launches the CPU, waits
// for cpu_done, and then streams the result bytes out through the UART transmitter.
// Optional feature macro UMC_CHECKSUM_EN: when it is defined, an XOR checksum byte
// follows the result stream.
module uart_mem_sequencer #(
  parameter int INS_BYTES = 256,
  parameter int IMG_BYTES = 65536,
  parameter int OUT_BASE  = 65536,
  parameter int OUT_BYTES = 16384,
  parameter int ADDR_W    = 19,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [7:0]        ins_addr,
  output logic [7:0]        ins_data,
  output logic              ins_we,
  output logic [ADDR_W-1:0] img_addr,
  output logic [7:0]        img_data,
  output logic              img_we,
  input  logic [7:0]        img_q,
  output logic              cpu_start,
  input  logic              cpu_done,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    LOAD_INS = 3'd0,
    LOAD_IMG = 3'd1,
    START    = 3'd2,
    RUN      = 3'd3,
    RD       = 3'd4,
    TX       = 3'd5,
    WAIT     = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] INS_LAST = ADDR_W'(INS_BYTES - 1);
  localparam logic [ADDR_W-1:0] IMG_LAST = ADDR_W'(IMG_BYTES - 1);
  localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_BYTES - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(OUT_BASE);
  localparam logic [7:0]        LAT      = 8'(RD_LAT);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic [7:0]        lat_reg, lat_next;        // cycles spent in RD on the current address
  logic              seen_busy_reg, seen_busy_next; // tx_busy has been seen high since tx_start
  logic              settle_reg, settle_next;  // one WAIT cycle has already elapsed
  logic [7:0]        tx_data_reg, tx_data_next;
`ifdef UMC_CHECKSUM_EN
  logic [7:0]        sum_reg, sum_next;        // XOR of the result bytes sent so far
  logic              sum_phase_reg, sum_phase_next; // the byte in flight is the checksum
`endif

  assign state_o = state_reg;
  assign tx_data = tx_data_reg;

  // State and counter registers; reset aborts the job at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= LOAD_INS;
      count_reg     <= '0;
      lat_reg       <= '0;
      seen_busy_reg <= 1'b0;
      settle_reg    <= 1'b0;
      tx_data_reg   <= '0;
`ifdef UMC_CHECKSUM_EN
      sum_reg       <= '0;
      sum_phase_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      lat_reg       <= lat_next;
      seen_busy_reg <= seen_busy_next;
      settle_reg    <= settle_next;
      tx_data_reg   <= tx_data_next;
`ifdef UMC_CHECKSUM_EN
      sum_reg       <= sum_next;
      sum_phase_reg <= sum_phase_next;
`endif
    end
  end

  // Next-state logic and the same-cycle RAM, CPU and TX strobes.
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    lat_next       = lat_reg;
    seen_busy_next = seen_busy_reg;
    settle_next    = settle_reg;
    tx_data_next   = tx_data_reg;
`ifdef UMC_CHECKSUM_EN
    sum_next       = sum_reg;
    sum_phase_next = sum_phase_reg;
`endif
    ins_addr  = '0;
    ins_data  = '0;
    ins_we    = 1'b0;
    img_addr  = '0;
    img_data  = '0;
    img_we    = 1'b0;
    tx_start  = 1'b0;
    cpu_start = 1'b0;

    case (state_reg)
      LOAD_INS: begin
        ins_addr = count_reg[7:0];
        if (rx_valid) begin
          ins_we   = 1'b1;
          ins_data = rx_data;
          if (count_reg == INS_LAST) begin
            count_next = '0;
            state_next = LOAD_IMG;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      LOAD_IMG: begin
        img_addr = count_reg;
        if (rx_valid) begin
          img_we   = 1'b1;
          img_data = rx_data;
          if (count_reg == IMG_LAST) begin
            count_next = '0;
            state_next = START;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      START: begin
        cpu_start  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (cpu_done) begin
          count_next = '0;
          lat_next   = '0;
          state_next = RD;
`ifdef UMC_CHECKSUM_EN
          sum_next       = '0;
          sum_phase_next = 1'b0;
`endif
        end
      end
      RD: begin
        // The address is held steady; once the RAM latency has elapsed, img_q is
        // re-captured every cycle until the transmitter is free.
        img_addr = BASE + count_reg;
        if (lat_reg >= LAT) begin
          tx_data_next = img_q;
          if (!tx_busy) state_next = TX;
        end else begin
          lat_next = lat_reg + 8'd1;
        end
      end
      TX: begin
        tx_start       = 1'b1;
        seen_busy_next = 1'b0;
        settle_next    = 1'b0;
        state_next     = WAIT;
`ifdef UMC_CHECKSUM_EN
        if (!sum_phase_reg) sum_next = sum_reg ^ tx_data_reg;
`endif
      end
      WAIT: begin
        // The byte is done after a busy pulse has ended. If the transmitter never
        // raised busy, the byte is done two cycles after tx_start.
        if (tx_busy) seen_busy_next = 1'b1;
        settle_next = 1'b1;
        if (!tx_busy && (seen_busy_reg || settle_reg)) begin
`ifdef UMC_CHECKSUM_EN
          if (sum_phase_reg) begin
            count_next = '0;
            state_next = DONE;
          end else if (count_reg == OUT_LAST) begin
            sum_phase_next = 1'b1;
            tx_data_next   = sum_reg;
            state_next     = TX;
          end else begin
            count_next = count_reg + 1'b1;
            lat_next   = '0;
            state_next = RD;
          end
`else
          if (count_reg == OUT_LAST) begin
            count_next = '0;
            state_next = DONE;
          end else begin
            count_next = count_reg + 1'b1;
            lat_next   = '0;
            state_next = RD;
          end
`endif
        end
      end
      DONE: begin
        // The first byte of the next job is program byte 0.
        if (rx_valid) begin
          ins_we     = 1'b1;
          ins_data   = rx_data;
          count_next = ADDR_W'(1);
          state_next = LOAD_INS;
        end
      end
      default: state_next = LOAD_INS;
    endcase

    // While reset is asserted, no write may slip through on a live rx_valid.
    if (!rst_n) begin
      ins_we   = 1'b0;
      ins_data = '0;
      img_we   = 1'b0;
      img_data = '0;
    end
  end

endmodule

// File: tb/tb_uart_mem_sequencer.sv
// Scoreboard bench for uart_mem_sequencer with a small job geometry:
// 4 program bytes, 8 image bytes, and 2 result bytes at image address 8.
module tb_uart_mem_sequencer;

  localparam int INS_BYTES = 4;
  localparam int IMG_BYTES = 8;
  localparam int OUT_BASE  = 8;
  localparam int OUT_BYTES = 2;
  localparam int ADDR_W    = 19;
  localparam int RD_LAT    = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [7:0]        ins_addr;
  logic [7:0]        ins_data;
  logic              ins_we;
  logic [ADDR_W-1:0] img_addr;
  logic [7:0]        img_data;
  logic              img_we;
  logic [7:0]        img_q;
  logic              cpu_start;
  logic              cpu_done;
  logic [2:0]        state_o;

  always #5 clk = ~clk;

  uart_mem_sequencer #(
    .INS_BYTES(INS_BYTES), .IMG_BYTES(IMG_BYTES), .OUT_BASE(OUT_BASE),
    .OUT_BYTES(OUT_BYTES), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .ins_addr(ins_addr), .ins_data(ins_data), .ins_we(ins_we),
    .img_addr(img_addr), .img_data(img_data), .img_we(img_we), .img_q(img_q),
    .cpu_start(cpu_start), .cpu_done(cpu_done), .state_o(state_o)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Image RAM model. Input bytes are held at 0..7. The result bytes at 8..9 are
  // preloaded by the bench. The read is registered, which gives one clock of latency.
  logic [7:0] img_mem [0:7];
  logic [7:0] res_mem [0:1];
  always @(posedge clk) begin
    if (img_we) img_mem[img_addr[2:0]] <= img_data;
    img_q <= (img_addr < 19'd8) ? img_mem[img_addr[2:0]] : res_mem[img_addr[0]];
  end

  // Transmitter model: busy goes high for busy_len cycles after tx_start (0 = never busy).
  int busy_len = 3;
  int busy_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_start && busy_len > 0) begin
      tx_busy  <= 1'b1;
      busy_cnt <= busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end
  end

  // Scoreboard queues. Writes are encoded as {kind, 0, addr[18:0], data}: kind 1 = ins, 2 = img.
  logic [31:0] wr_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] got_wr;
  int          cpu_starts = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ins_we || img_we) begin
        check_eq("we_exclusive", {31'b0, ins_we & img_we}, 32'd0);
        got_wr = ins_we ? {4'd1, 1'b0, 11'd0, ins_addr, ins_data}
                        : {4'd2, 1'b0, img_addr, img_data};
        $display("write kind=%0d addr=%0h data=%02h", got_wr[31:28], got_wr[26:8], got_wr[7:0]);
        if (wr_q.size() == 0) check_eq("unexpected_write", got_wr, 32'd0);
        else check_eq("write", got_wr, wr_q.pop_front());
      end
      if (tx_start) begin
        $display("tx byte=%02h", tx_data);
        check_eq("tx_busy_at_start", {31'b0, tx_busy}, 32'd0);
        check_eq("tx_cpu_exclusive", {31'b0, cpu_start}, 32'd0);
        if (tx_q.size() == 0) check_eq("unexpected_tx", {24'b0, tx_data}, 32'hFFFF_FFFF);
        else check_eq("tx_byte", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
      end
      if (cpu_start) cpu_starts++;
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_ins(input int addr, input logic [7:0] b);
    wr_q.push_back({4'd1, 1'b0, 11'd0, 8'(addr), b});
    send_rx(b);
  endtask

  task automatic send_img(input int addr, input logic [7:0] b);
    wr_q.push_back({4'd2, 1'b0, 19'(addr), b});
    send_rx(b);
  endtask

  task automatic push_results();
    tx_q.push_back(8'h5A);
    tx_q.push_back(8'hC3);
`ifdef UMC_CHECKSUM_EN
    tx_q.push_back(8'h99);
`endif
  endtask

  task automatic wait_done();
    int n = 0;
    while (state_o !== 3'd7 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("reach_done", {29'b0, state_o}, 32'd7);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_strobes"}, {28'b0, ins_we, img_we, tx_start, cpu_start}, 32'd0);
    check_eq({tag, "_ins"}, {16'b0, ins_addr, ins_data}, 32'd0);
    check_eq({tag, "_img_addr"}, {13'b0, img_addr}, 32'd0);
    check_eq({tag, "_img_data"}, {24'b0, img_data}, 32'd0);
    check_eq({tag, "_tx_data"}, {24'b0, tx_data}, 32'd0);
    check_eq({tag, "_state"}, {29'b0, state_o}, 32'd0);
  endtask

  // The image-load, run and stream part of a job. It is shared by both jobs.
  task automatic image_and_run(input int job);
    for (int i = 0; i < IMG_BYTES; i++) send_img(i, 8'hA0 + 8'(i));
    @(posedge clk); #1;
    check_eq("state_run", {29'b0, state_o}, 32'd3);
    check_eq("cpu_start_count", cpu_starts, job);
    push_results();
    cpu_done = 1'b1;
    wait_done();
    cpu_done = 1'b0;
    check_eq("tx_queue_drained", tx_q.size(), 32'd0);
    check_eq("wr_queue_drained", wr_q.size(), 32'd0);
  endtask

  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cpu_done = 1'b0;
    res_mem[0] = 8'h5A;
    res_mem[1] = 8'hC3;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Job 1: the transmitter asserts a busy pulse after each byte.
    send_ins(0, 8'h11);
    send_ins(1, 8'h22);
    send_ins(2, 8'h33);
    send_ins(3, 8'h44);
    check_eq("state_load_img", {29'b0, state_o}, 32'd1);
    for (int i = 0; i < IMG_BYTES; i++) send_img(i, 8'hA0 + 8'(i));
    @(posedge clk); #1;
    check_eq("state_run", {29'b0, state_o}, 32'd3);
    check_eq("cpu_start_count", cpu_starts, 32'd1);
    send_rx(8'hFF);  // must be dropped while the CPU runs
    check_eq("state_run_after_rx", {29'b0, state_o}, 32'd3);
    for (int i = 0; i < IMG_BYTES; i++)
      check_eq("img_mem_kept", {24'b0, img_mem[i]}, 32'hA0 + i);
    push_results();
    cpu_done = 1'b1;
    wait_done();
    cpu_done = 1'b0;
    check_eq("tx_queue_drained", tx_q.size(), 32'd0);

    // Job 2: started from DONE by an rx byte. The transmitter never raises busy.
    busy_len = 0;
    send_ins(0, 8'h77);
    check_eq("restart_state", {29'b0, state_o}, 32'd0);
    send_ins(1, 8'h22);
    send_ins(2, 8'h33);
    send_ins(3, 8'h44);
    check_eq("state_load_img2", {29'b0, state_o}, 32'd1);
    image_and_run(2);

    // Job 3: aborted by reset during the image load, while rx_valid is high.
    busy_len = 3;
    send_ins(0, 8'h01);
    send_ins(1, 8'h02);
    send_ins(2, 8'h03);
    send_ins(3, 8'h04);
    send_img(0, 8'hB0);
    send_img(1, 8'hB1);
    send_img(2, 8'hB2);
    @(posedge clk); #1;
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_ins(0, 8'h55);
    check_eq("after_reset_state", {29'b0, state_o}, 32'd0);
    check_eq("after_reset_queue", wr_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_mem_sequencer.md
Name: uart_mem_sequencer

Overview:
- Sequences the dual-port instruction RAM and image RAM from the UART side (port b) for a complete job.
- Job flow: load the program bytes, load the input image bytes, hand control to the CPU, then stream the processed image back out through the UART transmitter.
- Sits between uart_rx/uart_tx and the UART-side ports of memory_unit. It drives the CPU start/done handshake.

Parameters:
- INS_BYTES, 256: number of program bytes written to instruction RAM, addresses 0..INS_BYTES-1.
- IMG_BYTES, 65536: number of input image bytes written to image RAM, addresses 0..IMG_BYTES-1.
- OUT_BASE, 65536: image RAM address of the first result byte.
- OUT_BYTES, 16384: number of result bytes streamed back.
- ADDR_W, 19: image RAM address width.
- RD_LAT, 1: image RAM read latency in clocks (address to q).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle strobe requesting transmission of tx_data.
- tx_busy  in  1  transmitter busy; high from the cycle after tx_start until the byte is done.
- ins_addr  out  8  instruction RAM port-b address.
- ins_data  out  8  instruction RAM port-b write data.
- ins_we  out  1  instruction RAM port-b write enable.
- img_addr  out  ADDR_W  image RAM port-b address.
- img_data  out  8  image RAM port-b write data.
- img_we  out  1  image RAM port-b write enable.
- img_q  in  8  image RAM port-b read data.
- cpu_start  out  1  one-cycle pulse that launches the CPU.
- cpu_done  in  1  level from the CPU; high when the job is finished.
- state_o  out  3  current state encoding, for LEDs/debug.

Behaviour:
- Reset (async, rst_n low): every output is 0; state = LOAD_INS; counters = 0. Reset asserted mid-job aborts immediately; no partial write completes after rst_n falls.
- States (state_o encoding): LOAD_INS=0, LOAD_IMG=1, START=2, RUN=3, RD=4, TX=5, WAIT=6, DONE=7.
- LOAD_INS:
  - Each rx_valid writes in the same cycle: ins_addr = count, ins_data = rx_data, ins_we = 1 for exactly one cycle.
  - count increments after each write.
  - After write INS_BYTES-1: count clears and the state goes to LOAD_IMG.
- LOAD_IMG:
  - Same as LOAD_INS, using img_addr/img_data/img_we.
  - After write IMG_BYTES-1: count clears and the state goes to START.
- START: cpu_start = 1 for one cycle, then the state goes to RUN.
- RUN:
  - Waits for cpu_done = 1, sampled in RUN only.
  - A cpu_done that is already high on entry to RUN is honoured on the next cycle.
  - On cpu_done = 1: count clears and the state goes to RD.
- RD:
  - Drives img_addr = OUT_BASE + count, with img_we = 0.
  - Waits RD_LAT cycles, then captures img_q into tx_data and goes to TX.
- TX: enters only when tx_busy = 0. Pulses tx_start for one cycle, then goes to WAIT.
- WAIT:
  - Waits for tx_busy to rise and then fall, or for tx_busy = 0 two cycles after tx_start.
  - Then count increments. If count was OUT_BYTES-1 the state goes to DONE; otherwise it returns to RD.
- DONE:
  - All strobes stay 0.
  - The next rx_valid restarts a job: that byte is written as program byte 0 and the state goes to LOAD_INS with count = 1.
- Ignored inputs:
  - rx_valid in START, RUN, RD, TX and WAIT is ignored (dropped). No write enable rises.
  - cpu_done outside RUN is ignored.
- Widths: address arithmetic is ADDR_W bits, and OUT_BASE + count wraps modulo 2^ADDR_W. ins_addr is the low 8 bits of count.
- Exclusivity: ins_we and img_we are never high in the same cycle. Only one of tx_start and cpu_start is asserted in any cycle.

Optional Feature:
- Macro: UMC_CHECKSUM_EN.
- When defined:
  - An 8-bit XOR accumulator clears on entry to RD from RUN and XORs every transmitted result byte.
  - After byte OUT_BYTES-1 completes, one extra byte equal to the accumulator is sent through the same TX/WAIT handshake before DONE.
- When not defined: exactly OUT_BYTES bytes are sent and there is no accumulator logic.

Test Plan (INS_BYTES=4, IMG_BYTES=8, OUT_BASE=8, OUT_BYTES=2, RD_LAT=1):
- Reset release, then rx bytes 0x11,0x22,0x33,0x44 -> ins_we pulses at ins_addr 0..3 with those data; state_o=1 after the 4th byte.
- Eight rx bytes 0xA0..0xA7 -> img_we at img_addr 0..7 with 0xA0..0xA7; a single cpu_start pulse; state_o=3.
- rx_valid with 0xFF during RUN -> no ins_we/img_we; RAM contents unchanged.
- Preload RAM[8]=0x5A and RAM[9]=0xC3; raise cpu_done -> img_addr 8 then 9 read; tx bytes 0x5A, 0xC3, each tx_start only while tx_busy=0; state_o=7. With UMC_CHECKSUM_EN, a third byte 0x99 follows.
- Drop rst_n during LOAD_IMG after 3 bytes -> all outputs 0 asynchronously; state_o=0; the next rx byte is written to ins_addr 0.
- In DONE, send rx byte 0x77 -> ins_we at addr 0 with 0x77; state_o=0; a full second job completes identically.
